jacobi_sweep_scheduler: RTL and testbench

- Sequences cyclic-by-row Jacobi sweeps over the N×N symmetric matrix held in the row-pair buffer (row_1/row_2 source, ready_for_AA_T style readiness).
- Generates every pivot pair (p,q) with p<q, hands each pair to the rotation datapath with a valid/ready handshake and waits for its completion.
- Tracks the sweep count and stops on convergence or after MAX_SWEEPS.

---
 rtl/jacobi_pkg.sv | 27 ++
 rtl/jacobi_sweep_scheduler_if.sv | 37 +++
 rtl/jacobi_pair_gen.sv | 45 ++++
 rtl/jacobi_sweep_scheduler.sv | 129 ++++++++++++
 tb/tb_jacobi_sweep_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jacobi_pkg.sv
// Shared defaults and FSM state encoding for the Jacobi sweep scheduler.
// Revision: 1.0
`default_nettype none

package jacobi_pkg;

  localparam int N_DEF          = 32;
  localparam int AW_DEF         = 5;
  localparam int MAX_SWEEPS_DEF = 8;
  localparam int SW_DEF         = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SRC = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_ROT = 3'd3,
    S_NEXT     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  function automatic int pairs_per_sweep(input int n);
    return (n * (n - 1)) / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jacobi_sweep_scheduler_if.sv
// Control/handshake bundle between the sweep scheduler, row buffer and rotation datapath.
// Revision: 1.0
`default_nettype none

interface jacobi_sweep_scheduler_if #(
  parameter int AW = jacobi_pkg::AW_DEF,
  parameter int SW = jacobi_pkg::SW_DEF
);

  logic          start;
  logic          src_ready;
  logic          pair_valid;
  logic          pair_ready;
  logic [AW-1:0] pair_p;
  logic [AW-1:0] pair_q;
  logic          rot_done;
  logic          rot_small;
  logic          busy;
  logic          done;
  logic          converged;
  logic [SW-1:0] sweep_cnt;

  // Scheduler side
  modport master (
    input  start, src_ready, pair_ready, rot_done, rot_small,
    output pair_valid, pair_p, pair_q, busy, done, converged, sweep_cnt
  );

  // Controller / datapath side
  modport slave (
    output start, src_ready, pair_ready, rot_done, rot_small,
    input  pair_valid, pair_p, pair_q, busy, done, converged, sweep_cnt
  );

endinterface

`default_nettype wire

// File: rtl/jacobi_pair_gen.sv
// Cyclic-by-row pivot index counter: (0,1)(0,2)..(0,N-1)(1,2)..(N-2,N-1).
// Revision: 1.0
`default_nettype none

module jacobi_pair_gen
  import jacobi_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          first,
  input  wire logic          advance,
  output logic      [AW-1:0] p,
  output logic      [AW-1:0] q,
  output logic               last_pair
);

  localparam logic [AW-1:0] LAST_P = AW'(N - 2);
  localparam logic [AW-1:0] LAST_Q = AW'(N - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p <= '0;
      q <= AW'(1);
    end else if (first) begin
      p <= '0;
      q <= AW'(1);
    end else if (advance && !last_pair) begin
      // Row wrap: next row starts just right of the new diagonal element.
      if (q != LAST_Q) begin
        q <= q + AW'(1);
      end else begin
        p <= p + AW'(1);
        q <= p + AW'(2);
      end
    end
  end

  assign last_pair = (p == LAST_P) && (q == LAST_Q);

endmodule

`default_nettype wire

// File: rtl/jacobi_sweep_scheduler.sv
// Sequences Jacobi sweeps: issues each pivot pair, waits for the rotation, stops on convergence or sweep limit.
// Revision: 1.0
`default_nettype none

module jacobi_sweep_scheduler
  import jacobi_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int AW         = AW_DEF,
  parameter int MAX_SWEEPS = MAX_SWEEPS_DEF,
  parameter int SW         = SW_DEF
) (
  input  wire logic               clk,
  input  wire logic               reset,
  jacobi_sweep_scheduler_if.master bus
);

  localparam logic [SW-1:0] SWEEP_LIMIT = SW'(MAX_SWEEPS);

  state_t          state, state_nxt;
  logic            all_small, all_small_nxt;
  logic [SW-1:0]   sweep_cnt, sweep_cnt_nxt;
  logic            converged, converged_nxt;
  logic            pg_first;
  logic            pg_advance;
  logic            last_pair;
  logic [AW-1:0]   p;
  logic [AW-1:0]   q;

  jacobi_pair_gen #(
    .N  (N),
    .AW (AW)
  ) u_pair_gen (
    .clk       (clk),
    .reset     (reset),
    .first     (pg_first),
    .advance   (pg_advance),
    .p         (p),
    .q         (q),
    .last_pair (last_pair)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      all_small <= 1'b1;
      sweep_cnt <= '0;
      converged <= 1'b0;
    end else begin
      state     <= state_nxt;
      all_small <= all_small_nxt;
      sweep_cnt <= sweep_cnt_nxt;
      converged <= converged_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    all_small_nxt = all_small;
    sweep_cnt_nxt = sweep_cnt;
    converged_nxt = converged;
    pg_first      = 1'b0;
    pg_advance    = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt     = S_WAIT_SRC;
          sweep_cnt_nxt = '0;
          converged_nxt = 1'b0;
          all_small_nxt = 1'b1;
          pg_first      = 1'b1;
        end
      end

      S_WAIT_SRC: begin
        if (bus.src_ready) state_nxt = S_ISSUE;
      end

      S_ISSUE: begin
        if (bus.pair_ready) state_nxt = S_WAIT_ROT;
      end

      S_WAIT_ROT: begin
        if (bus.rot_done) begin
          all_small_nxt = all_small & bus.rot_small;
          state_nxt     = S_NEXT;
        end
      end

      S_NEXT: begin
        if (!last_pair) begin
          pg_advance = 1'b1;
          state_nxt  = S_ISSUE;
        end else begin
          // End of sweep; a converged sweep reports convergence even at the limit.
          sweep_cnt_nxt = sweep_cnt + SW'(1);
          if (all_small || (sweep_cnt + SW'(1) == SWEEP_LIMIT)) begin
            converged_nxt = all_small;
            state_nxt     = S_DONE;
          end else begin
            pg_first      = 1'b1;
            all_small_nxt = 1'b1;
            state_nxt     = S_ISSUE;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.pair_valid = (state == S_ISSUE);
  assign bus.pair_p     = p;
  assign bus.pair_q     = q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.converged  = converged;
  assign bus.sweep_cnt  = sweep_cnt;

endmodule

`default_nettype wire

// File: tb/tb_jacobi_sweep_scheduler.sv
// Directed bench for jacobi_sweep_scheduler: N=4 (limit 3) instance plus a default N=32 instance.
// Revision: 1.0
`default_nettype none

module tb_jacobi_sweep_scheduler;
  import jacobi_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  jacobi_sweep_scheduler_if #(.AW(2), .SW(4)) bus4 ();
  jacobi_sweep_scheduler_if #(.AW(5), .SW(4)) bus32 ();

  jacobi_sweep_scheduler #(.N(4), .AW(2), .MAX_SWEEPS(3), .SW(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  jacobi_sweep_scheduler #(.N(32), .AW(5), .MAX_SWEEPS(8), .SW(4)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  int errors = 0;
  int checks = 0;
  int log_p [64];
  int log_q [64];
  int exp_p [6] = '{0, 0, 0, 1, 1, 2};
  int exp_q [6] = '{1, 2, 3, 2, 3, 3};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Acts as the N=4 rotation datapath: accepts pairs, answers rot_done one cycle later.
  task automatic serve4(input int small_from, input int budget, output int hs, output int saw_done);
    bit acc;
    acc = 1'b0;
    hs = 0;
    saw_done = 0;
    for (int c = 0; c < budget; c++) begin
      step();
      bus4.rot_done = 1'b0;
      if (acc) begin
        bus4.rot_done  = 1'b1;
        bus4.rot_small = ((hs - 1) >= small_from);
        acc = 1'b0;
      end
      if (bus4.done === 1'b1) begin
        saw_done = 1;
        break;
      end
      if (bus4.pair_valid === 1'b1 && bus4.pair_ready === 1'b1) begin
        if (hs < 64) begin
          log_p[hs] = int'(bus4.pair_p);
          log_q[hs] = int'(bus4.pair_q);
        end
        hs++;
        acc = 1'b1;
      end
    end
    bus4.rot_done = 1'b0;
  endtask

  task automatic start4();
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (bus4.pair_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", bus4.pair_valid); end
    checks++; if (bus4.pair_p !== 2'd0) begin errors++; $display("FAIL rst_p: got %0d want 0", bus4.pair_p); end
    checks++; if (bus4.pair_q !== 2'd1) begin errors++; $display("FAIL rst_q: got %0d want 1", bus4.pair_q); end
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", bus4.busy); end
    checks++; if (bus4.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", bus4.done); end
    checks++; if (bus4.converged !== 1'b0) begin errors++; $display("FAIL rst_conv: got %0b want 0", bus4.converged); end
    checks++; if (bus4.sweep_cnt !== 4'd0) begin errors++; $display("FAIL rst_sweep: got %0d want 0", bus4.sweep_cnt); end
    checks++; if (bus32.pair_q !== 5'd1) begin errors++; $display("FAIL rst_q32: got %0d want 1", bus32.pair_q); end
    reset = 1'b1;
    step();
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b want 0", bus4.busy); end
  endtask

  task automatic test_max_sweeps();
    int hs, saw;
    bus4.src_ready = 1'b1;
    bus4.pair_ready = 1'b1;
    bus4.rot_small = 1'b0;
    start4();
    serve4(1000, 200, hs, saw);
    checks++; if (saw !== 1) begin errors++; $display("FAIL max_done_seen: got %0d want 1", saw); end
    checks++; if (bus4.busy !== 1'b1) begin errors++; $display("FAIL max_busy_at_done: got %0b want 1", bus4.busy); end
    checks++; if (hs !== 18) begin errors++; $display("FAIL max_handshakes: got %0d want 18", hs); end
    for (int i = 0; i < 18 && i < hs; i++) begin
      checks++;
      if (log_p[i] !== exp_p[i % 6] || log_q[i] !== exp_q[i % 6]) begin
        errors++;
        $display("FAIL max_pair%0d: got (%0d,%0d) want (%0d,%0d)", i, log_p[i], log_q[i], exp_p[i % 6], exp_q[i % 6]);
      end
    end
    step();
    checks++; if (bus4.done !== 1'b0) begin errors++; $display("FAIL max_done_pulse: got %0b want 0", bus4.done); end
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL max_idle: got %0b want 0", bus4.busy); end
    checks++; if (bus4.sweep_cnt !== 4'd3) begin errors++; $display("FAIL max_sweep_cnt: got %0d want 3", bus4.sweep_cnt); end
    checks++; if (bus4.converged !== 1'b0) begin errors++; $display("FAIL max_conv: got %0b want 0", bus4.converged); end
    bus4.pair_ready = 1'b0;
  endtask

  task automatic test_converge();
    int hs, saw;
    bus4.src_ready = 1'b1;
    bus4.pair_ready = 1'b1;
    start4();
    serve4(6, 200, hs, saw);
    checks++; if (saw !== 1) begin errors++; $display("FAIL conv_done_seen: got %0d want 1", saw); end
    checks++; if (hs !== 12) begin errors++; $display("FAIL conv_handshakes: got %0d want 12", hs); end
    for (int i = 0; i < 12 && i < hs; i++) begin
      checks++;
      if (log_p[i] !== exp_p[i % 6] || log_q[i] !== exp_q[i % 6]) begin
        errors++;
        $display("FAIL conv_pair%0d: got (%0d,%0d) want (%0d,%0d)", i, log_p[i], log_q[i], exp_p[i % 6], exp_q[i % 6]);
      end
    end
    bus4.pair_ready = 1'b0;
    step();
    step();
    step();
    checks++; if (bus4.sweep_cnt !== 4'd2) begin errors++; $display("FAIL conv_sweep_cnt: got %0d want 2", bus4.sweep_cnt); end
    checks++; if (bus4.converged !== 1'b1) begin errors++; $display("FAIL conv_flag_held: got %0b want 1", bus4.converged); end
    reset = 1'b0;
    #1;
    checks++; if (bus4.converged !== 1'b0) begin errors++; $display("FAIL conv_rst_clear: got %0b want 0", bus4.converged); end
    checks++; if (bus4.sweep_cnt !== 4'd0) begin errors++; $display("FAIL conv_rst_sweep: got %0d want 0", bus4.sweep_cnt); end
    #2;
    reset = 1'b1;
    step();
  endtask

  task automatic test_src_wait();
    bus4.src_ready = 1'b0;
    bus4.pair_ready = 1'b0;
    start4();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus4.busy !== 1'b1 || bus4.pair_valid !== 1'b0) begin
        errors++;
        $display("FAIL srcwait_c%0d: got busy=%0b valid=%0b want busy=1 valid=0", i, bus4.busy, bus4.pair_valid);
      end
      step();
    end
    bus4.src_ready = 1'b1;
    step();
    bus4.src_ready = 1'b0;
    checks++;
    if (bus4.pair_valid !== 1'b1 || bus4.pair_p !== 2'd0 || bus4.pair_q !== 2'd1) begin
      errors++;
      $display("FAIL srcwait_first: got valid=%0b (%0d,%0d) want valid=1 (0,1)", bus4.pair_valid, bus4.pair_p, bus4.pair_q);
    end
  endtask

  task automatic test_hold_and_spurious();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus4.rot_done = 1'b1;
        bus4.start = 1'b1;
      end
      step();
      bus4.rot_done = 1'b0;
      bus4.start = 1'b0;
      checks++;
      if (bus4.pair_valid !== 1'b1 || bus4.pair_p !== 2'd0 || bus4.pair_q !== 2'd1) begin
        errors++;
        $display("FAIL hold_c%0d: got valid=%0b (%0d,%0d) want valid=1 (0,1)", i, bus4.pair_valid, bus4.pair_p, bus4.pair_q);
      end
    end
    bus4.pair_ready = 1'b1;
    step();
    bus4.pair_ready = 1'b0;
    checks++; if (bus4.pair_valid !== 1'b0) begin errors++; $display("FAIL hold_valid_drop: got %0b want 0", bus4.pair_valid); end
    checks++; if (bus4.busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %0b want 1", bus4.busy); end
    bus4.rot_done = 1'b1;
    bus4.rot_small = 1'b0;
    step();
    bus4.rot_done = 1'b0;
    step();
    checks++;
    if (bus4.pair_valid !== 1'b1 || bus4.pair_p !== 2'd0 || bus4.pair_q !== 2'd2) begin
      errors++;
      $display("FAIL hold_no_skip: got valid=%0b (%0d,%0d) want valid=1 (0,2)", bus4.pair_valid, bus4.pair_p, bus4.pair_q);
    end
  endtask

  task automatic test_reset_mid_run();
    int ep [3] = '{0, 0, 1};
    int eq [3] = '{2, 3, 2};
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus4.pair_valid !== 1'b1 || int'(bus4.pair_p) !== ep[k] || int'(bus4.pair_q) !== eq[k]) begin
        errors++;
        $display("FAIL mid_pair%0d: got valid=%0b (%0d,%0d) want valid=1 (%0d,%0d)", k, bus4.pair_valid, bus4.pair_p, bus4.pair_q, ep[k], eq[k]);
      end
      bus4.pair_ready = 1'b1;
      step();
      bus4.pair_ready = 1'b0;
      if (k < 2) begin
        bus4.rot_done = 1'b1;
        step();
        bus4.rot_done = 1'b0;
        step();
      end
    end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus4.pair_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b want 0", bus4.pair_valid); end
    checks++; if (bus4.pair_p !== 2'd0 || bus4.pair_q !== 2'd1) begin errors++; $display("FAIL mid_rst_pq: got (%0d,%0d) want (0,1)", bus4.pair_p, bus4.pair_q); end
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b want 0", bus4.busy); end
    for (int i = 0; i < 3; i++) begin
      bus4.rot_done = (i == 0);
      step();
      checks++; if (bus4.done !== 1'b0) begin errors++; $display("FAIL mid_no_done%0d: got %0b want 0", i, bus4.done); end
    end
    bus4.rot_done = 1'b0;
    reset = 1'b1;
    bus4.src_ready = 1'b1;
    start4();
    step();
    checks++;
    if (bus4.pair_valid !== 1'b1 || bus4.pair_p !== 2'd0 || bus4.pair_q !== 2'd1 || bus4.sweep_cnt !== 4'd0) begin
      errors++;
      $display("FAIL mid_restart: got valid=%0b (%0d,%0d) sweep=%0d want valid=1 (0,1) sweep=0",
               bus4.pair_valid, bus4.pair_p, bus4.pair_q, bus4.sweep_cnt);
    end
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
  endtask

  task automatic test_full_sweep32();
    int hs, saw, ep, eq, lp, lq;
    bit acc;
    hs = 0; saw = 0; ep = 0; eq = 1; lp = -1; lq = -1; acc = 1'b0;
    bus32.src_ready = 1'b1;
    bus32.pair_ready = 1'b1;
    bus32.rot_small = 1'b1;
    bus32.start = 1'b1;
    step();
    bus32.start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      step();
      bus32.rot_done = acc;
      acc = 1'b0;
      if (bus32.done === 1'b1) begin
        saw = 1;
        break;
      end
      if (bus32.pair_valid === 1'b1) begin
        checks++;
        if (int'(bus32.pair_p) !== ep || int'(bus32.pair_q) !== eq) begin
          errors++;
          $display("FAIL n32_pair%0d: got (%0d,%0d) want (%0d,%0d)", hs, bus32.pair_p, bus32.pair_q, ep, eq);
        end
        lp = int'(bus32.pair_p);
        lq = int'(bus32.pair_q);
        hs++;
        acc = 1'b1;
        if (eq < 31) begin
          eq++;
        end else begin
          ep++;
          eq = ep + 1;
        end
      end
    end
    bus32.rot_done = 1'b0;
    bus32.pair_ready = 1'b0;
    checks++; if (saw !== 1) begin errors++; $display("FAIL n32_done_seen: got %0d want 1", saw); end
    checks++; if (hs !== 496) begin errors++; $display("FAIL n32_handshakes: got %0d want 496", hs); end
    checks++; if (lp !== 30 || lq !== 31) begin errors++; $display("FAIL n32_last_pair: got (%0d,%0d) want (30,31)", lp, lq); end
    step();
    checks++; if (bus32.converged !== 1'b1) begin errors++; $display("FAIL n32_conv: got %0b want 1", bus32.converged); end
    checks++; if (bus32.sweep_cnt !== 4'd1) begin errors++; $display("FAIL n32_sweep_cnt: got %0d want 1", bus32.sweep_cnt); end
  endtask

  initial begin
    bus4.start = 1'b0;  bus4.src_ready = 1'b0;  bus4.pair_ready = 1'b0;
    bus4.rot_done = 1'b0;  bus4.rot_small = 1'b0;
    bus32.start = 1'b0; bus32.src_ready = 1'b0; bus32.pair_ready = 1'b0;
    bus32.rot_done = 1'b0; bus32.rot_small = 1'b0;

    test_reset();
    test_max_sweeps();
    test_converge();
    test_src_wait();
    test_hold_and_spurious();
    test_reset_mid_run();
    test_full_sweep32();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
